// File: rtl/mod_n_updown_counter.sv
// Run-time modulus up/down/ping-pong counter with registered count, direction and terminal-count pulse.
// Optional tick prescaler compiled in with `define MOD_CNT_PRESCALE_EN (divides enabled clocks by PRESCALE).
module mod_n_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    // Out-of-range parameters elaborate into this marker block so they are easy to spot.
    if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 2 || PRESCALE > 65535) begin : g_param_out_of_range
    end

    logic             tick;
    logic             small_mod;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] turn_val;
    logic [WIDTH-1:0] count_nx;
    logic             dir_nx;
    logic             tc_nx;

`ifdef MOD_CNT_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] psc;
    logic          psc_last;

    assign psc_last = (psc == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            psc <= '0;
        end else if (en) begin
            psc <= psc_last ? '0 : psc + PW'(1);
        end
    end

    assign tick = en & ~load & psc_last;
`else
    assign tick = en & ~load;
`endif

    // Boundary values are forced to zero for degenerate moduli so no wrapped subtraction escapes.
    assign small_mod = (mod_val < WIDTH'(2));
    assign top_val   = small_mod ? '0 : mod_val - WIDTH'(1);
    assign turn_val  = small_mod ? '0 : mod_val - WIDTH'(2);

    always_comb begin
        count_nx = count;
        dir_nx   = dir;
        tc_nx    = 1'b0;
        if (load) begin
            dir_nx = 1'b1;
            if (small_mod)
                count_nx = '0;
            else if (load_val < mod_val)
                count_nx = load_val;
            else
                count_nx = top_val;
        end else if (tick && mode_t'(mode) != MODE_HOLD) begin
            if (small_mod) begin
                count_nx = '0;
                dir_nx   = 1'b1;
                tc_nx    = 1'b1;
            end else begin
                unique case (mode_t'(mode))
                    MODE_UP: begin
                        dir_nx = 1'b1;
                        if (count >= top_val) begin
                            count_nx = '0;
                            tc_nx    = 1'b1;
                        end else begin
                            count_nx = count + WIDTH'(1);
                        end
                    end
                    MODE_DOWN: begin
                        dir_nx = 1'b0;
                        if (count == '0 || count >= mod_val) begin
                            count_nx = top_val;
                            tc_nx    = 1'b1;
                        end else begin
                            count_nx = count - WIDTH'(1);
                        end
                    end
                    MODE_PING: begin
                        if (dir) begin
                            if (count >= top_val) begin
                                count_nx = turn_val;
                                dir_nx   = 1'b0;
                                tc_nx    = 1'b1;
                            end else begin
                                count_nx = count + WIDTH'(1);
                            end
                        end else if (count >= mod_val) begin
                            count_nx = turn_val;
                            tc_nx    = 1'b1;
                        end else if (count == '0) begin
                            count_nx = WIDTH'(1);
                            dir_nx   = 1'b1;
                            tc_nx    = 1'b1;
                        end else begin
                            count_nx = count - WIDTH'(1);
                        end
                    end
                    default: begin
                        count_nx = count;
                        dir_nx   = dir;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            dir   <= 1'b1;
            tc    <= 1'b0;
        end else begin
            count <= count_nx;
            dir   <= dir_nx;
            tc    <= tc_nx;
        end
    end

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter and modulus width in bits; legal range 2..32.
REQ-002 Parameter: PRESCALE, default 4, enabled clocks per count tick when prescaling is compiled in; legal range 2..65535.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  reset, synchronous, active-high; clock clk.
REQ-005 Port: en  input  1  count enable; no tick when low.
REQ-006 Port: load  input  1  synchronous parallel load request.
REQ-007 Port: load_val  input  WIDTH  value to load.
REQ-008 Port: mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
REQ-009 Port: mod_val  input  WIDTH  run-time modulus; count range 0..mod_val-1.
REQ-010 Port: count  output  WIDTH  registered count value.
REQ-011 Port: dir  output  1  registered direction, 1 = up, 0 = down.
REQ-012 Port: tc  output  1  registered terminal-count pulse.

Function
REQ-013 The priority SHALL be rst > load > tick > hold, with all state updated only on the rising edge of clk.
REQ-014 A tick SHALL occur on an edge where en=1 and load=0, gated further by the prescaler when MOD_CNT_PRESCALE_EN is defined.
REQ-015 Load SHALL set count to load_val if load_val < mod_val, else to mod_val-1, SHALL set dir=1 and tc=0, and SHALL apply in every mode, including hold.
REQ-016 In mode 00, a tick SHALL set count to 0 with tc=1 if count >= mod_val-1, else to count+1 with tc=0; dir SHALL be 1.
REQ-017 In mode 01, a tick SHALL set count to mod_val-1 with tc=1 if count==0 or count >= mod_val, else to count-1 with tc=0; dir SHALL be 0.
REQ-018 In mode 10 with dir=1, a tick SHALL set count to mod_val-2 with dir=0 and tc=1 if count >= mod_val-1, else to count+1.
REQ-019 In mode 10 with dir=0, a tick SHALL do the following:
- if count >= mod_val: set count to mod_val-2, keep dir=0, tc=1.
- if count==0: set count to 1, dir=1, tc=1.
- otherwise: set count to count-1, tc=0.
REQ-020 In mode 11, a tick SHALL leave count and dir unchanged with tc=0.
REQ-021 If mod_val < 2, a tick in modes 00, 01 or 10 SHALL force count=0, dir=1, tc=1.
REQ-022 On any edge without a tick or load, count and dir SHALL hold and tc SHALL be 0, so tc is high for exactly one cycle per wrap or turn.
REQ-023 A mode or mod_val change SHALL take effect on the next tick, with no extra latency and no reset needed.
REQ-024 All arithmetic SHALL be WIDTH bits unsigned; mod_val-1 and mod_val-2 SHALL never be evaluated when mod_val < 2.

Reset
REQ-025 rst=1 at a rising edge SHALL set count=0, dir=1, tc=0 and clear the prescaler, overriding load and en, including mid-count and mid-ping-pong.
REQ-026 The first tick after reset release SHALL behave as from count=0, dir=1.

Configuration
REQ-027 Macro MOD_CNT_PRESCALE_EN defined: an internal counter SHALL advance on each en=1, load=0 edge; a tick SHALL occur only when it equals PRESCALE-1, which wraps it to 0; load and rst SHALL clear it.
REQ-028 Macro MOD_CNT_PRESCALE_EN undefined: every en=1, load=0 edge SHALL be a tick, and PRESCALE SHALL be ignored with no prescaler logic present.

Verification
REQ-029 Up wrap: WIDTH=8, mod_val=10, mode=00, en=1 for 12 clocks after reset -> count sequence 1..9,0,1,2; tc high only in the cycle count shows 0.
REQ-030 Down and out-of-range: count=7, then mod_val changed to 5, mode=01, one tick -> count=4, tc=1; the next tick -> count=3, tc=0.
REQ-031 Ping-pong: mod_val=4, mode=10, from reset -> sequence 1,2,3,2,1,0,1; dir falls when count=2 after 3; tc pulses in the cycles count shows 2 (turn from 3) and 1 (turn from 0).
REQ-032 Load priority: load=1, load_val=200, mod_val=50, en=1, mode=11 -> count=49, dir=1, tc=0; load with rst=1 on the same edge -> count=0.
REQ-033 Degenerate modulus: mod_val=1 and mod_val=0, mode=00, en=1 -> count stays 0, tc=1 every cycle; mode=11 -> tc=0.
REQ-034 Prescale (MOD_CNT_PRESCALE_EN, PRESCALE=4): mod_val=3, mode=00, en=1 for 12 clocks -> count changes every 4th clock (1,2,0); en dropped for 2 clocks mid-period delays the tick by 2 clocks.
